// File: rtl/softmax_in_collector.sv
// softmax_in_collector
// Collects N signed Q4.12 elements from a valid/ready stream into a flat
// vector, tracks the running signed maximum, and presents the complete
// vector (plus its maximum) to a downstream softmax until it is consumed.
//
// Optional feature, selected by the macro SOFTMAX_IN_OVERLAP_EN:
//   defined   : while the vector is held, in_ready follows out_ready, so an
//               element arriving in the handshake cycle starts the next
//               vector (no idle cycle between vectors).
//   undefined : in_ready is low for the whole hold period.
//
// The reset port is named rst but is asynchronous and active-low.

module softmax_in_collector #(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N*16-1:0] in_x_flat,
  output logic [15:0]     max_x
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [N*16-1:0]   data_q, data_d;
  logic [15:0]       max_q, max_d;

  logic              accept;
  logic              handshake;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;

  // Handshake qualifiers derived from the current state
  always_comb begin
    out_valid = (state_q == ST_HOLD);
`ifdef SOFTMAX_IN_OVERLAP_EN
    in_ready  = (state_q == ST_FILL) || out_ready;
`else
    in_ready  = (state_q == ST_FILL);
`endif
    accept    = in_valid && in_ready;
    handshake = out_valid && out_ready;
  end

  // Next-state logic: slot selection, counter and FILL/HOLD sequencing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    wr_idx  = idx_q;
    unique case (state_q)
      ST_FILL: begin
        if (accept) begin
          wr_en  = 1'b1;
          wr_idx = idx_q;
          if (idx_q == LAST_IDX) begin
            state_d = ST_HOLD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (handshake) begin
          state_d = ST_FILL;
`ifdef SOFTMAX_IN_OVERLAP_EN
          // accept implies handshake here; the element opens the next vector
          if (accept) begin
            wr_en  = 1'b1;
            wr_idx = '0;
            if (N == 1) begin
              state_d = ST_HOLD;
              idx_d   = '0;
            end else begin
              idx_d = IDX_W'(1);
            end
          end
`endif
        end
      end
      default: begin
        state_d = ST_FILL;
        idx_d   = '0;
      end
    endcase
  end

  // Datapath: write the selected slot and update the running signed maximum
  always_comb begin
    data_d = data_q;
    max_d  = max_q;
    if (wr_en) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (IDX_W'(i) == wr_idx) begin
          data_d[i*16 +: 16] = in_data;
        end
      end
      if (wr_idx == '0) begin
        max_d = in_data;
      end else if ($signed(in_data) > $signed(max_q)) begin
        max_d = in_data;
      end
    end
  end

  // State, counter and vector registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FILL;
      idx_q   <= '0;
      data_q  <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      max_q   <= max_d;
    end
  end

  assign in_x_flat = data_q;
  assign max_x     = max_q;

endmodule

// File: tb/tb_softmax_in_collector.sv
// Scoreboard bench for softmax_in_collector: the stimulus process pushes the
// expected vector before feeding its elements; the monitor pops and compares
// on every output handshake. Build with or without SOFTMAX_IN_OVERLAP_EN.

module tb_softmax_in_collector;

  localparam int N = 4;
`ifdef SOFTMAX_IN_OVERLAP_EN
  localparam int PERIOD_EXP = N;
  localparam logic HOLD_READY_EXP = 1'b1;
`else
  localparam int PERIOD_EXP = N + 1;
  localparam logic HOLD_READY_EXP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [15:0]     in_data;
  logic            out_valid;
  logic            out_ready;
  logic [N*16-1:0] in_x_flat;
  logic [15:0]     max_x;

  typedef struct packed {
    logic [N*16-1:0] flat;
    logic [15:0]     mx;
  } vec_t;

  vec_t exp_q[$];
  int   rise_cyc[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic ov_prev = 1'b0;

  softmax_in_collector #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .in_x_flat (in_x_flat),
    .max_x     (max_x)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: records out_valid rise times and scores each consumed vector
  always @(negedge clk) begin
    vec_t e;
    if (rst && out_valid && !ov_prev) rise_cyc.push_back(cyc);
    ov_prev = out_valid;
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vector: got %h expected none", in_x_flat);
      end else begin
        e = exp_q.pop_front();
        check("vec_flat", 64'(in_x_flat), 64'(e.flat));
        check("vec_max", 64'(max_x), 64'(e.mx));
      end
    end
  end

  task automatic send(input logic [15:0] d);
    int n;
    bit acc;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!acc && n < 50);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected accept of %h", n, d);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset state with the clock running
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_flat", 64'(in_x_flat), 64'd0);
    check("rst_max", 64'(max_x), 64'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Basic vector, back-to-back with out_ready=1
    out_ready = 1'b1;
    exp_q.push_back({64'h15DB_2771_FE18_EC80, 16'h2771});
    send(16'hEC80); send(16'hFE18); send(16'h2771);
    check("fill_out_valid", 64'(out_valid), 64'd0);
    send(16'h15DB);
    in_valid = 1'b0;
    check("latency_out_valid", 64'(out_valid), 64'd1);
    check("hold_in_ready", 64'(in_ready), 64'(HOLD_READY_EXP));
    @(posedge clk); #1;
    check("release_out_valid", 64'(out_valid), 64'd0);

    // All-negative with a tie, then backpressure in HOLD
    out_ready = 1'b0;
    exp_q.push_back({64'hFFFF_FFFF_8001_8000, 16'hFFFF});
    send(16'h8000); send(16'h8001); send(16'hFFFF); send(16'hFFFF);
    in_data = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_flat", 64'(in_x_flat), 64'hFFFF_FFFF_8001_8000);
      check("bp_max", 64'(max_x), 64'hFFFF);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_release_out_valid", 64'(out_valid), 64'd0);

    // Mid-fill asynchronous reset discards the partial vector
    send(16'h1111); send(16'h2222);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'd0);
    check("async_rst_flat", 64'(in_x_flat), 64'd0);
    check("async_rst_max", 64'(max_x), 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back({64'h0000_F000_0800_1000, 16'h1000});
    send(16'h1000); send(16'h0800); send(16'hF000); send(16'h0000);
    idle(2);

    // Valid gaps inside the basic stream
    exp_q.push_back({64'h15DB_2771_FE18_EC80, 16'h2771});
    send(16'hEC80); idle(2);
    send(16'hFE18); idle(1);
    send(16'h2771); idle(3);
    send(16'h15DB); idle(2);

    // Throughput with in_valid held high across two vectors
    rise_cyc.delete();
    exp_q.push_back({64'h0004_0003_0002_0001, 16'h0004});
    exp_q.push_back({64'h0008_0007_0006_0005, 16'h0008});
    for (int k = 1; k <= 8; k++) send(16'(k));
    idle(3);
    check("throughput_vectors", 64'(rise_cyc.size()), 64'd2);
    check("throughput_period",
          64'((rise_cyc.size() >= 2) ? (rise_cyc[1] - rise_cyc[0]) : 0),
          64'(PERIOD_EXP));

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
